mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store initiator that drives the synchronous-read, byte-strobed data/program memory port (addr, data_in, rd_strobe, wr_strobe[3:0], data_out) from the CPU side. It accepts one RV32 load/store request at a time and aligns the address to a word. Stores get byte-lane strobes and replicated write data. Loads wait out the memory read latency, then extract and sign- or zero-extend the result. Misaligned and illegal requests are trapped with no memory access.

Parameters:
READ_LATENCY, 1, cycles from the cycle mem_rd_strobe is high to the cycle mem_rdata is valid (legal 1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; equals (state==IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result (0 for stores and errors)
resp_err  out  1  qualifies resp_valid: misaligned or illegal funct3
mem_addr  out  32  {req_addr[31:2],2'b00}, registered
mem_wdata  out  32  lane-replicated store data, registered
mem_rd_strobe  out  1  read enable, one-cycle pulse
mem_wr_strobe  out  4  byte write enables, one-cycle pulse
mem_rdata  in  32  memory data_out

Behaviour:
- All outputs are registered except req_ready.
- Reset (sync): state=IDLE. On the next edge all of these go to 0: mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe, resp_valid, resp_rdata, resp_err. req_ready is 0 while rst=1 and 1 in the first cycle after rst falls.
- States: IDLE, STORE, LOAD_WAIT, RESP. Accept happens when req_valid & req_ready at edge T.
- Error check at accept: the request is an error if any of these holds:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - funct3 in {011,110,111};
  - store with funct3 in {100,101}.
  On error: go to RESP. In cycle T+1, resp_valid=1, resp_err=1, resp_rdata=0, all strobes 0. Return to IDLE at T+2.
- Store: cycle T+1 (state STORE):
  - mem_addr is valid; mem_wr_strobe = SB 4'b0001<<addr[1:0], SH addr[1]?4'b1100:4'b0011, SW 4'b1111.
  - mem_wdata = SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - resp_valid=1 in the same cycle, resp_err=0. IDLE at T+2, so stores occupy 2 cycles.
- Load: cycle T+1, mem_rd_strobe=1 and mem_addr is valid.
  - LOAD_WAIT counts READ_LATENCY cycles. mem_rdata is sampled in cycle T+1+READ_LATENCY.
  - lane = addr[1:0] is held from accept. LB/LBU: byte rdata[8*lane+:8], sign/zero-extended. LH/LHU: half rdata[16*addr[1]+:16], sign/zero-extended. LW: full word.
  - resp_valid=1 with the result in cycle T+2+READ_LATENCY (T+3 at default). IDLE the following cycle.
- resp_valid is high exactly one cycle per accepted request. No new request is accepted until IDLE.
- mem_rd_strobe and mem_wr_strobe are never nonzero in the same cycle, and never nonzero outside STORE or the first load cycle.
- mem_addr and mem_wdata hold their last values when idle. The memory ignores them without a strobe.
- Reset mid-operation aborts the request: no resp_valid, strobes 0 from the next edge, IDLE.
- req_valid while not ready: ignored. The request must be held by the requester.

Test Plan:
- Reset: rst=1 for 5 cycles with req_valid=1 -> no strobes, resp_valid=0 throughout; req_ready=1 in the first cycle after rst falls.
- SW addr=0x8, wdata=0xDEADBEEF -> next cycle mem_addr=0x8, mem_wr_strobe=4'b1111, mem_wdata=0xDEADBEEF, resp_valid=1 with err=0; req_ready=1 one cycle later.
- SB addr=0x13, wdata=0x000000A5 -> mem_addr=0x10, mem_wr_strobe=4'b1000, mem_wdata=0xA5A5A5A5. SH addr=0x12, wdata=0x1234 -> mem_wr_strobe=4'b1100, mem_wdata=0x12341234.
- Loads against a memory model holding word 0x80F17F01 at 0x4, READ_LATENCY=1:
  - LB 0x5 -> resp_rdata=0x0000007F, 3 cycles after accept.
  - LB 0x7 -> 0xFFFFFF80; LBU 0x7 -> 0x00000080.
  - LH 0x6 -> 0xFFFF80F1; LHU 0x6 -> 0x000080F1.
  - LW 0x4 -> 0x80F17F01.
- Errors: LW 0x6, SH 0x1, funct3=011 -> resp_valid=1, resp_err=1, resp_rdata=0 one cycle after accept; mem_rd_strobe and mem_wr_strobe stay 0.
- Latency and abort: READ_LATENCY=3, LW 0x0 -> resp 5 cycles after accept. rst pulsed in the LOAD_WAIT cycle -> no resp_valid, state IDLE, next request served normally.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding RV32 load/store initiator for a synchronous-read,
// byte-strobed memory port. Aligns the address to a word, builds byte strobes
// and lane-replicated store data, waits out the read latency for loads and
// extracts/extends the addressed byte, half or word. Misaligned or illegal
// requests complete immediately with resp_err and never touch memory.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE and outside reset.
// The requester holds the request stable until accepted. Every accepted
// request produces exactly one resp_valid pulse.
module mem_lsu #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_strobe,
    output logic [3:0]  mem_wr_strobe,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STORE     = 2'd1,
        LOAD_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_rd_strobe_q;
    logic [3:0]  mem_wr_strobe_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        req_err;
    logic [3:0]  st_strobe;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift_b;
    logic [31:0] ld_shift_h;
    logic [31:0] ld_data;

    // Reject misaligned halves/words, reserved funct3 and unsigned-store encodings
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Byte-lane strobes and replicated write data for the incoming store
    always_comb begin
        st_strobe = 4'b0000;
        st_wdata  = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_strobe = 4'b0001 << req_addr[1:0];
                st_wdata  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_strobe = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata  = {2{req_wdata[15:0]}};
            end
            default: begin
                st_strobe = 4'b1111;
                st_wdata  = req_wdata;
            end
        endcase
    end

    // Extract and extend the addressed lane of the returning read word
    always_comb begin
        ld_shift_b = mem_rdata >> {lane_q, 3'b000};
        ld_shift_h = mem_rdata >> {lane_q[1], 4'b0000};
        ld_data    = mem_rdata;
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift_b[7]}}, ld_shift_b[7:0]};
            3'b100:  ld_data = {24'd0, ld_shift_b[7:0]};
            3'b001:  ld_data = {{16{ld_shift_h[15]}}, ld_shift_h[15:0]};
            3'b101:  ld_data = {16'd0, ld_shift_h[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    // Control FSM with all memory-side and response outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 3'd0;
            lane_q          <= 2'd0;
            funct3_q        <= 3'd0;
            mem_addr_q      <= 32'd0;
            mem_wdata_q     <= 32'd0;
            mem_rd_strobe_q <= 1'b0;
            mem_wr_strobe_q <= 4'b0000;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= 32'd0;
        end else begin
            mem_rd_strobe_q <= 1'b0;
            mem_wr_strobe_q <= 4'b0000;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lane_q   <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_we) begin
                            state_q         <= STORE;
                            mem_addr_q      <= {req_addr[31:2], 2'b00};
                            mem_wdata_q     <= st_wdata;
                            mem_wr_strobe_q <= st_strobe;
                            resp_valid_q    <= 1'b1;
                        end else begin
                            state_q         <= LOAD_WAIT;
                            mem_addr_q      <= {req_addr[31:2], 2'b00};
                            mem_rd_strobe_q <= 1'b1;
                            cnt_q           <= 3'd0;
                        end
                    end
                end
                STORE: begin
                    state_q <= IDLE;
                end
                LOAD_WAIT: begin
                    // Data is valid in the cycle where the counter reaches the latency
                    if (cnt_q == 3'(READ_LATENCY)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ld_data;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE) && !rst;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_rd_strobe = mem_rd_strobe_q;
    assign mem_wr_strobe = mem_wr_strobe_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: one instance at READ_LATENCY=1 (a_*) and one at
// READ_LATENCY=3 (b_*), each backed by a small synchronous-read memory model.
module tb_mem_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // ---------------- instance A, READ_LATENCY = 1 ----------------
    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [2:0]  a_req_funct3 = 3'b010;
    logic [31:0] a_req_addr = 32'd0, a_req_wdata = 32'd0;
    logic        a_req_ready, a_resp_valid, a_resp_err, a_rd;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_wr;
    logic [1:0]  a_dbg_state;

    mem_lsu #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd_strobe(a_rd),
        .mem_wr_strobe(a_wr), .mem_rdata(a_mem_rdata), .dbg_state(a_dbg_state)
    );

    // ---------------- instance B, READ_LATENCY = 3 ----------------
    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [2:0]  b_req_funct3 = 3'b010;
    logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_rd;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_wr;
    logic [1:0]  b_dbg_state;

    mem_lsu #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd_strobe(b_rd),
        .mem_wr_strobe(b_wr), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
    );

    // ---------------- memory models ----------------
    // Read data only appears when the read strobe was high; otherwise garbage.
    logic [31:0] mem [16];
    logic [31:0] b_p1 = 32'd0, b_p2 = 32'd0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'hCAFEF00D;
        mem[1] = 32'h80F17F01;
    end

    always @(posedge clk) begin
        a_mem_rdata <= a_rd ? mem[a_mem_addr[5:2]] : 32'hBAD0BAD0;
        b_p1        <= b_rd ? mem[b_mem_addr[5:2]] : 32'hBAD1BAD1;
        b_p2        <= b_p1;
        b_mem_rdata <= b_p2;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request on A, let it be accepted at the next edge, then drop it.
    task automatic a_issue(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        a_req_we     = we;
        a_req_funct3 = f3;
        a_req_addr   = addr;
        a_req_wdata  = wdata;
        a_req_valid  = 1'b1;
        tick();
        a_req_valid  = 1'b0;
    endtask

    task automatic a_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        a_issue(1'b1, f3, addr, wdata);
        chk({tag, ".addr"},  a_mem_addr, exp_addr);
        chk({tag, ".strb"},  {28'd0, a_wr}, {28'd0, exp_strb});
        chk({tag, ".wdata"}, a_mem_wdata, exp_wdata);
        chk({tag, ".rd"},    {31'd0, a_rd}, 32'd0);
        chk({tag, ".valid"}, {31'd0, a_resp_valid}, 32'd1);
        chk({tag, ".err"},   {31'd0, a_resp_err}, 32'd0);
        chk({tag, ".busy"},  {31'd0, a_req_ready}, 32'd0);
        tick();
        chk({tag, ".ready"}, {31'd0, a_req_ready}, 32'd1);
        chk({tag, ".idle_strb"}, {28'd0, a_wr}, 32'd0);
        chk({tag, ".idle_valid"}, {31'd0, a_resp_valid}, 32'd0);
    endtask

    task automatic a_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
        a_issue(1'b0, f3, addr, 32'd0);
        chk({tag, ".rd"},    {31'd0, a_rd}, 32'd1);
        chk({tag, ".addr"},  a_mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".v1"},    {31'd0, a_resp_valid}, 32'd0);
        tick();
        chk({tag, ".rd_off"}, {31'd0, a_rd}, 32'd0);
        chk({tag, ".v2"},    {31'd0, a_resp_valid}, 32'd0);
        tick();
        chk({tag, ".valid"}, {31'd0, a_resp_valid}, 32'd1);
        chk({tag, ".err"},   {31'd0, a_resp_err}, 32'd0);
        chk({tag, ".data"},  a_resp_rdata, exp);
        tick();
        chk({tag, ".ready"}, {31'd0, a_req_ready}, 32'd1);
        chk({tag, ".v4"},    {31'd0, a_resp_valid}, 32'd0);
    endtask

    task automatic a_error(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        a_issue(we, f3, addr, 32'hFFFFFFFF);
        chk({tag, ".valid"}, {31'd0, a_resp_valid}, 32'd1);
        chk({tag, ".err"},   {31'd0, a_resp_err}, 32'd1);
        chk({tag, ".data"},  a_resp_rdata, 32'd0);
        chk({tag, ".rd"},    {31'd0, a_rd}, 32'd0);
        chk({tag, ".strb"},  {28'd0, a_wr}, 32'd0);
        tick();
        chk({tag, ".ready"}, {31'd0, a_req_ready}, 32'd1);
        chk({tag, ".v2"},    {31'd0, a_resp_valid}, 32'd0);
        chk({tag, ".rd2"},   {31'd0, a_rd}, 32'd0);
    endtask

    // LW on B: strobe one cycle after accept, response five cycles after accept.
    task automatic b_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        b_req_we     = 1'b0;
        b_req_funct3 = 3'b010;
        b_req_addr   = addr;
        b_req_valid  = 1'b1;
        tick();
        b_req_valid  = 1'b0;
        chk({tag, ".rd"}, {31'd0, b_rd}, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk({tag, ".wait"}, {31'd0, b_resp_valid}, 32'd0);
            chk({tag, ".rd_off"}, {31'd0, b_rd}, 32'd0);
        end
        tick();
        chk({tag, ".valid"}, {31'd0, b_resp_valid}, 32'd1);
        chk({tag, ".data"},  b_resp_rdata, exp);
        tick();
        chk({tag, ".ready"}, {31'd0, b_req_ready}, 32'd1);
        chk({tag, ".v6"},    {31'd0, b_resp_valid}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held with a valid request pending on A
        rst         = 1'b1;
        a_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst.rd",    {31'd0, a_rd}, 32'd0);
            chk("rst.wr",    {28'd0, a_wr}, 32'd0);
            chk("rst.valid", {31'd0, a_resp_valid}, 32'd0);
            chk("rst.ready", {31'd0, a_req_ready}, 32'd0);
        end
        chk("rst.addr",  a_mem_addr, 32'd0);
        chk("rst.wdata", a_mem_wdata, 32'd0);
        chk("rst.rdata", a_resp_rdata, 32'd0);
        chk("rst.err",   {31'd0, a_resp_err}, 32'd0);
        chk("rst.b_ready", {31'd0, b_req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", {31'd0, a_req_ready}, 32'd1);
        a_req_valid = 1'b0;
        tick();

        // Stores
        a_store("sw", 3'b010, 32'h8,  32'hDEADBEEF, 32'h8,  4'b1111, 32'hDEADBEEF);
        a_store("sb", 3'b000, 32'h13, 32'h000000A5, 32'h10, 4'b1000, 32'hA5A5A5A5);
        a_store("sh", 3'b001, 32'h12, 32'h00001234, 32'h10, 4'b1100, 32'h12341234);
        a_store("sb0", 3'b000, 32'h21, 32'h0000003C, 32'h20, 4'b0010, 32'h3C3C3C3C);
        a_store("sh0", 3'b001, 32'h30, 32'hABCD5678, 32'h30, 4'b0011, 32'h56785678);

        // Loads against word 0x80F17F01 at 0x4
        a_load("lb5",  3'b000, 32'h5, 32'h0000007F);
        a_load("lb7",  3'b000, 32'h7, 32'hFFFFFF80);
        a_load("lbu7", 3'b100, 32'h7, 32'h00000080);
        a_load("lh6",  3'b001, 32'h6, 32'hFFFF80F1);
        a_load("lhu6", 3'b101, 32'h6, 32'h000080F1);
        a_load("lw4",  3'b010, 32'h4, 32'h80F17F01);
        a_load("lbu4", 3'b100, 32'h4, 32'h00000001);
        a_load("lh4",  3'b001, 32'h4, 32'h00007F01);

        // Errors: no memory access, immediate error response
        a_error("e_lw6",  1'b0, 3'b010, 32'h6);
        a_error("e_sh1",  1'b1, 3'b001, 32'h1);
        a_error("e_f011", 1'b0, 3'b011, 32'h0);
        a_error("e_sbu",  1'b1, 3'b100, 32'h0);
        a_error("e_lhu3", 1'b0, 3'b101, 32'h3);

        // Longer read latency
        b_load("b_lw0", 32'h0, 32'hCAFEF00D);

        // Abort: reset pulsed during LOAD_WAIT on B
        b_req_we     = 1'b0;
        b_req_funct3 = 3'b010;
        b_req_addr   = 32'h4;
        b_req_valid  = 1'b1;
        tick();
        b_req_valid  = 1'b0;
        chk("abort.rd", {31'd0, b_rd}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.rd_off", {31'd0, b_rd}, 32'd0);
        chk("abort.idle", {30'd0, b_dbg_state}, 32'd0);
        #1;
        chk("abort.ready", {31'd0, b_req_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort.no_resp", {31'd0, b_resp_valid}, 32'd0);
        end
        b_load("b_after", 32'h4, 32'h80F17F01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
